// File: rtl/sobel_window_if.sv
// Pixel-stream / 3x3-window bundle between a raster pixel source and sobel_window.
// Latency: none (wires only).
// Backpressure: none; the source pushes one pixel per cycle whenever pixel_valid_i is high.
interface sobel_window_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0]             pixel_i;
    logic                               pixel_valid_i;
    logic                               sof_i;
    // [vector][pix]: vector0 = oldest row, vector2 = newest row; pix0 = leftmost column, pix2 = newest column
    logic [2:0][2:0][PIXEL_WIDTH-1:0]   matrix_pixels_o;
    logic                               matrix_valid_o;
    logic                               frame_done_o;

    modport master (
        output pixel_i, pixel_valid_i, sof_i,
        input  matrix_pixels_o, matrix_valid_o, frame_done_o
    );

    modport slave (
        input  pixel_i, pixel_valid_i, sof_i,
        output matrix_pixels_o, matrix_valid_o, frame_done_o
    );
endinterface

// File: rtl/sobel_window.sv
// 3x3 sliding-window generator over a raster grayscale stream using two line buffers.
// Latency: one cycle from the accepting edge to the window / frame_done output.
// Backpressure: none; every valid pixel is consumed, outputs hold while input is idle.
module sobel_window #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 16,
    parameter int IMG_HEIGHT  = 16
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    sobel_window_if.slave bus
);
    localparam int CW = ($clog2(IMG_WIDTH)  > 0) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = ($clog2(IMG_HEIGHT) > 0) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;

    logic [PIXEL_WIDTH-1:0] lb_top [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb_mid [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] top_rd;
    logic [PIXEL_WIDTH-1:0] mid_rd;

    logic [2:0][2:0][PIXEL_WIDTH-1:0] win;
    logic                             win_vld;
    logic                             frame_done;
    logic                             accept;

    assign accept = bus.pixel_valid_i;

    // A start-of-frame pixel is always position (0,0), overriding whatever the counters say.
    always_comb begin
        cur_col = col;
        cur_row = row;
        if (bus.sof_i) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign top_rd = lb_top[cur_col];
    assign mid_rd = lb_mid[cur_col];

    // Raster position counters; advance only on accepted pixels.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col <= '0;
                row <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    // Line buffers shift one row down per accepted pixel; contents are rewritten before use, so no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb_top[cur_col] <= mid_rd;
            lb_mid[cur_col] <= bus.pixel_i;
        end
    end

    // Window shifts left and takes the new column (two buffered rows plus the incoming pixel).
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            win <= '0;
        end else if (accept) begin
            for (int v = 0; v < 3; v++) begin
                win[v][0] <= win[v][1];
                win[v][1] <= win[v][2];
            end
            win[0][2] <= top_rd;
            win[1][2] <= mid_rd;
            win[2][2] <= bus.pixel_i;
        end
    end

    // Window is complete only from row 2 / column 2 onward, which also excludes row-wrap straddles.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            win_vld    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            win_vld    <= accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            frame_done <= accept && (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        end
    end

    assign bus.matrix_pixels_o = win;
    assign bus.matrix_valid_o  = win_vld;
    assign bus.frame_done_o    = frame_done;
endmodule

// File: tb/tb_sobel_window.sv
module tb_sobel_window;
    localparam int PW = 8;

    typedef logic [2:0][2:0][PW-1:0] win_t;
    typedef struct packed {
        win_t win;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset_a;
    logic nreset_b;

    sobel_window_if #(.PIXEL_WIDTH(PW)) bus_a ();
    sobel_window_if #(.PIXEL_WIDTH(PW)) bus_b ();

    sobel_window #(.PIXEL_WIDTH(PW), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut_a (
        .clk_i    (clk),
        .nreset_i (nreset_a),
        .bus      (bus_a.slave)
    );

    sobel_window #(.PIXEL_WIDTH(PW), .IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
        .clk_i    (clk),
        .nreset_i (nreset_b),
        .bus      (bus_b.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    win_t seen_a[$];
    int   win_cnt_a  = 0;
    int   done_cnt_a = 0;
    int   win_cnt_b  = 0;
    int   done_cnt_b = 0;
    bit   gap_mode   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected window for an 8-wide image whose pixel is base + 8*row + col.
    function automatic win_t ramp_win(input int base, input int r, input int c);
        win_t w;
        for (int v = 0; v < 3; v++)
            for (int p = 0; p < 3; p++)
                w[v][p] = PW'(base + 8 * (r - 2 + v) + (c - 2 + p));
        return w;
    endfunction

    // One cycle of DUT A input; called at posedge+1, returns at the next posedge+1.
    task automatic cycle_a(input logic vld, input logic sof, input logic [PW-1:0] pix);
        bus_a.pixel_valid_i = vld;
        bus_a.sof_i         = sof;
        bus_a.pixel_i       = pix;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame_a(input int base, input bit gapped, input bit sof_first, input int stop_at);
        for (int i = 0; i < 64; i++) begin
            if (i == stop_at) return;
            if ((i / 8) >= 2 && (i % 8) >= 2)
                q_a.push_back('{win: ramp_win(base, i / 8, i % 8), done: (i == 63)});
            cycle_a(1'b1, sof_first && (i == 0), PW'(base + i));
            if (gapped) cycle_a(1'b0, 1'b0, PW'($urandom));
        end
    endtask

    // Monitor for DUT A: scoreboard compare, gap rules, hold-while-idle.
    logic prev_mvld_a = 0;
    logic prev_in_vld_a = 0;
    logic prev_nrst_a = 0;
    win_t prev_mat_a = '0;
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.matrix_valid_o) begin
            win_cnt_a++;
            seen_a.push_back(bus_a.matrix_pixels_o);
            if (q_a.size() == 0) begin
                check("a_unexpected_window", 72'(bus_a.matrix_pixels_o), 72'(0));
                checks++;
                errors++;
                $display("FAIL a_unexpected_window actual=valid required=no window");
            end else begin
                e = q_a.pop_front();
                check("a_window", 72'(bus_a.matrix_pixels_o), 72'(e.win));
                check("a_frame_done", 72'(bus_a.frame_done_o), 72'(e.done));
            end
            if (gap_mode) check("a_gap_b2b_valid", 72'(prev_mvld_a), 72'(0));
        end else if (bus_a.frame_done_o) begin
            check("a_done_without_window", 72'(bus_a.frame_done_o), 72'(0));
        end
        if (bus_a.frame_done_o) done_cnt_a++;
        if (nreset_a && prev_nrst_a && !prev_in_vld_a)
            check("a_hold_idle", 72'(bus_a.matrix_pixels_o), 72'(prev_mat_a));
        prev_mvld_a   = bus_a.matrix_valid_o;
        prev_in_vld_a = bus_a.pixel_valid_i;
        prev_nrst_a   = nreset_a;
        prev_mat_a    = bus_a.matrix_pixels_o;
    end

    // Monitor for DUT B.
    always @(negedge clk) begin
        exp_t e;
        if (bus_b.matrix_valid_o) begin
            win_cnt_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_window actual=valid required=no window");
            end else begin
                e = q_b.pop_front();
                check("b_window", 72'(bus_b.matrix_pixels_o), 72'(e.win));
                check("b_frame_done", 72'(bus_b.frame_done_o), 72'(e.done));
            end
        end else if (bus_b.frame_done_o) begin
            check("b_done_without_window", 72'(bus_b.frame_done_o), 72'(0));
        end
        if (bus_b.frame_done_o) done_cnt_b++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int   w0, d0;
        win_t exp_first;
        win_t all255;

        nreset_a = 1'b0;
        nreset_b = 1'b0;
        bus_a.pixel_i = '0; bus_a.pixel_valid_i = 1'b0; bus_a.sof_i = 1'b0;
        bus_b.pixel_i = '0; bus_b.pixel_valid_i = 1'b0; bus_b.sof_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_matrix", 72'(bus_a.matrix_pixels_o), 72'(0));
        check("rst_a_valid",  72'(bus_a.matrix_valid_o),  72'(0));
        check("rst_a_done",   72'(bus_a.frame_done_o),    72'(0));
        check("rst_b_matrix", 72'(bus_b.matrix_pixels_o), 72'(0));
        nreset_a = 1'b1;
        nreset_b = 1'b1;
        cycle_a(1'b0, 1'b0, '0);

        // Ramp, continuous
        w0 = win_cnt_a; d0 = done_cnt_a;
        send_frame_a(0, 1'b0, 1'b1, 64);
        cycle_a(1'b0, 1'b0, '0);
        cycle_a(1'b0, 1'b0, '0);
        check("ramp_windows", 72'(win_cnt_a - w0), 72'(36));
        check("ramp_done",    72'(done_cnt_a - d0), 72'(1));
        exp_first[0] = {8'd2,  8'd1,  8'd0};
        exp_first[1] = {8'd10, 8'd9,  8'd8};
        exp_first[2] = {8'd18, 8'd17, 8'd16};
        if (seen_a.size() > w0) check("ramp_first_window", 72'(seen_a[w0]), 72'(exp_first));
        else check("ramp_first_window_missing", 72'(seen_a.size()), 72'(w0 + 1));

        // Gapped ramp
        gap_mode = 1;
        w0 = win_cnt_a; d0 = done_cnt_a;
        send_frame_a(0, 1'b1, 1'b1, 64);
        cycle_a(1'b0, 1'b0, '0);
        gap_mode = 0;
        check("gap_windows", 72'(win_cnt_a - w0), 72'(36));
        check("gap_done",    72'(done_cnt_a - d0), 72'(1));

        // Mid-frame SOF at col 4 row 3, then a full new frame
        w0 = win_cnt_a; d0 = done_cnt_a;
        send_frame_a(0, 1'b0, 1'b1, 3 * 8 + 4);
        send_frame_a(100, 1'b0, 1'b1, 64);
        cycle_a(1'b0, 1'b0, '0);
        check("sof_abort_windows", 72'(win_cnt_a - w0), 72'(8 + 36));
        check("sof_abort_done",    72'(done_cnt_a - d0), 72'(1));

        // Reset in row 5, then a full frame without sof
        send_frame_a(0, 1'b0, 1'b1, 5 * 8 + 3);
        cycle_a(1'b0, 1'b0, '0);
        check("pre_reset_q_empty", 72'(q_a.size()), 72'(0));
        nreset_a = 1'b0;
        #1;
        check("async_rst_matrix", 72'(bus_a.matrix_pixels_o), 72'(0));
        check("async_rst_valid",  72'(bus_a.matrix_valid_o),  72'(0));
        check("async_rst_done",   72'(bus_a.frame_done_o),    72'(0));
        repeat (3) @(posedge clk);
        #1;
        nreset_a = 1'b1;
        w0 = win_cnt_a; d0 = done_cnt_a;
        send_frame_a(50, 1'b0, 1'b0, 64);
        cycle_a(1'b0, 1'b0, '0);
        check("post_reset_windows", 72'(win_cnt_a - w0), 72'(36));
        check("post_reset_done",    72'(done_cnt_a - d0), 72'(1));
        check("a_q_empty",          72'(q_a.size()), 72'(0));

        // 3x3 constant 255 image
        for (int v = 0; v < 3; v++) all255[v] = {8'd255, 8'd255, 8'd255};
        for (int i = 0; i < 9; i++) begin
            if (i == 8) q_b.push_back('{win: all255, done: 1'b1});
            bus_b.pixel_valid_i = 1'b1;
            bus_b.sof_i         = (i == 0);
            bus_b.pixel_i       = 8'd255;
            @(posedge clk);
            #1;
        end
        bus_b.pixel_valid_i = 1'b0;
        bus_b.sof_i         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b_windows",  72'(win_cnt_b),  72'(1));
        check("b_done",     72'(done_cnt_b), 72'(1));
        check("b_q_empty",  72'(q_b.size()), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_window.md
SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter PIXEL_WIDTH, default 8, grayscale pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 16, pixels per image row; legal range 3..256.
REQ-003 Parameter IMG_HEIGHT, default 16, rows per frame; legal range 3..256.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 nreset_i  input  1  asynchronous, active-low reset.
REQ-006 pixel_i  input  PIXEL_WIDTH  grayscale pixel, raster order (left to right, top to bottom).
REQ-007 pixel_valid_i  input  1  pixel_i accepted on every rising edge where high; no backpressure.
REQ-008 sof_i  input  1  start of frame; meaningful only when pixel_valid_i is high.
REQ-009 matrix_pixels_o  output  sobel_matrix (9*PIXEL_WIDTH)  3x3 window; vector0 = oldest row, vector2 = newest row, pix0 = leftmost column, pix2 = newest column.
REQ-010 matrix_valid_o  output  1  matrix_pixels_o holds a complete, in-image window this cycle.
REQ-011 frame_done_o  output  1  one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 Column counter col (0..IMG_WIDTH-1) and row counter row (0..IMG_HEIGHT-1) advance only on accepted pixels.
- col wraps IMG_WIDTH-1 -> 0 and increments row.
- row wraps IMG_HEIGHT-1 -> 0 when col wraps.
REQ-013 Accepted pixel with sof_i=1 is taken as position (0,0), regardless of current counters; the previous frame is aborted with no frame_done_o pulse.
REQ-014 Two line buffers of IMG_WIDTH entries each (lb_top, lb_mid). On an accepted pixel at column c, read lb_top[c] and lb_mid[c], then write lb_top[c] <= old lb_mid[c] and lb_mid[c] <= pixel_i in the same cycle.
REQ-015 Window shift on an accepted pixel: pix0 <= pix1 and pix1 <= pix2 in every vector; the new pix2 column is vector0 = old lb_top[c], vector1 = old lb_mid[c], vector2 = pixel_i.
REQ-016 matrix_valid_o is registered and rises on the edge after an accepted pixel at row>=2 and col>=2; it is low in the cycle after any edge with pixel_valid_i=0.
REQ-017 Latency is one cycle from the accepting edge to the window output. Outputs per frame: exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) valid windows.
REQ-018 matrix_pixels_o holds its value while pixel_valid_i is low. matrix_valid_o must never be high for windows straddling a row wrap; the col>=2 rule guarantees this.
REQ-019 frame_done_o is registered and pulses for one cycle after the accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1); that edge also presents the final valid window.
REQ-020 The block contains no arithmetic beyond the counters; counter widths are $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT), with a minimum of 1 bit.

Reset
REQ-021 While nreset_i is low: col=0, row=0, all nine window registers 0, matrix_valid_o=0, frame_done_o=0.
REQ-022 Line-buffer contents are not reset. They are fully rewritten before any window depending on them is flagged valid.
REQ-023 Reset asserted mid-frame aborts the frame. The first accepted pixel after reset release is position (0,0) whether or not sof_i is high.

Verification
REQ-024 Ramp: IMG_WIDTH=8, IMG_HEIGHT=8, pixel = 8*row+col, continuous valid with sof on the first pixel -> 36 valid windows. The first window (edge after pixel (2,2)) is vector0={0,1,2}, vector1={8,9,10}, vector2={16,17,18}. frame_done_o pulses once, on the edge after pixel 63.
REQ-025 Gapped input: same image, pixel_valid_i toggled 1,0,1,0 -> identical window sequence. matrix_valid_o is never high two cycles in a row, and matrix_pixels_o is stable during gaps.
REQ-026 Mid-frame SOF: assert sof_i at pixel (4,3) of the ramp frame, then send a full new frame -> no frame_done_o for the aborted frame and no valid window until new position (2,2). The new frame yields 36 correct windows.
REQ-027 Reset mid-frame: drop nreset_i for 3 cycles during row 5 -> all outputs are 0 immediately (asynchronous). The next full frame, sent without sof, yields 36 correct windows.
REQ-028 Constant image of 255 with IMG_WIDTH=IMG_HEIGHT=3 -> exactly one valid window with all nine pixels = 255, and frame_done_o on the same edge.
